hazard_unit: RTL
================

# hazard_unit

Pipeline hazard controller for the 5-stage RV32 core, sitting between ID and EX, directly upstream of the forwarding logic. It decides each cycle whether the front end advances, stalls or flushes. It covers three cases: load-use hazards that forwarding cannot cover, taken-branch/jump flushes resolved in EX, and multi-cycle MUL/DIV occupancy of EX. It drives the PC, IF/ID and ID/EX write enables and flushes, plus the EX/MEM bubble.

## Interface
Parameters:
- MUL_CYCLES, 3, total EX cycles for MUL* (≥1)
- DIV_CYCLES, 33, total EX cycles for DIV*/REM* (≥1)

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous, active-low reset
- ID_Rs1, ID_Rs2  in  5 each  source registers of the instruction in ID
- ID_UsesRs1, ID_UsesRs2  in  1 each  the ID instruction actually reads that source
- EX_MemRead  in  1  the EX instruction is a load
- EX_Rd  in  5  destination register of the EX instruction
- EX_BranchTaken  in  1  the EX instruction redirects the PC (taken branch, JAL, JALR)
- EX_MulDiv  in  1  the EX instruction is an M-extension op
- EX_IsDiv  in  1  that M op is DIV/DIVU/REM/REMU
- PC_Write  out  1  PC register enable
- IF_ID_Write  out  1  IF/ID register enable
- IF_ID_Flush  out  1  IF/ID register loads a NOP
- ID_EX_Write  out  1  ID/EX register enable
- ID_EX_Flush  out  1  ID/EX register loads a bubble (all control bits 0)
- EX_MEM_Bubble  out  1  EX/MEM register loads a bubble
- MulDiv_Busy  out  1  EX is occupied by an unfinished M op
- MulDiv_Done  out  1  last EX cycle of an M op; the result is valid this cycle

## Operation
- **Load-use:**
  - Condition: loaduse = EX_MemRead & EX_Rd≠0 & ((ID_UsesRs1 & ID_Rs1==EX_Rd) | (ID_UsesRs2 & ID_Rs2==EX_Rd)).
  - Response: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1 for exactly one cycle.
- **Branch:** EX_BranchTaken=1 gives IF_ID_Flush=1 and ID_EX_Flush=1, with PC_Write=1 and IF_ID_Write=1.
- **MUL/DIV FSM:** states IDLE and BUSY, with a 6-bit down-counter cnt.
  - IDLE & EX_MulDiv: lat = EX_IsDiv ? DIV_CYCLES : MUL_CYCLES.
    - lat==1: MulDiv_Done=1 and no stall.
    - Otherwise: next state BUSY, cnt ← lat-2.
  - BUSY & cnt≠0: cnt decrements.
  - BUSY & cnt==0: MulDiv_Done=1, next state IDLE.
  - Stall condition: MulDiv_Busy = EX_MulDiv & ~MulDiv_Done, whether the FSM is in IDLE or BUSY. While MulDiv_Busy is high:
    - PC_Write=0, IF_ID_Write=0, ID_EX_Write=0 (EX holds).
    - EX_MEM_Bubble=1.
- **Priority**, highest first:
  1. MulDiv_Busy. EX_BranchTaken and loaduse are ignored; the EX instruction is an M op, so neither is legal.
  2. EX_BranchTaken. It overrides loaduse, because the stalled ID instruction is being squashed.
  3. loaduse.
  4. Default: all Write=1, all Flush/Bubble=0.
- EX_MulDiv is sampled only while in IDLE. In BUSY the input is assumed stable, since EX is held.

## Timing
- All outputs are combinational from the inputs and the registered FSM state. Zero-cycle decision latency.
- Reset: state←IDLE, cnt←0.
- Output values in the cycle after reset with inputs at 0: PC_Write=1, IF_ID_Write=1, ID_EX_Write=1, IF_ID_Flush=0, ID_EX_Flush=0, EX_MEM_Bubble=0, MulDiv_Busy=0, MulDiv_Done=0.
- An M op entering EX at cycle t stalls cycles t…t+lat-2. Done is asserted at t+lat-1. The next instruction enters EX at t+lat.
- Back-to-back M ops: the second is seen in IDLE at t+lat and starts a fresh count.
- Reset asserted mid-BUSY: the FSM returns to IDLE on that edge. Pipeline contents are the owner stages' responsibility. No Done pulse is generated.
- EX_Rd==0 never produces a stall.

## Configuration
- HAZARD_MULDIV_EN defined: the FSM, counter and parameters are active as described.
- Undefined:
  - The FSM and counter are not instantiated.
  - EX_MulDiv and EX_IsDiv are ignored.
  - MulDiv_Busy=0 and MulDiv_Done=0 constant.
  - Only load-use and branch logic remain.

## Structure
- The shared package riscv_hazard_pkg holds:
  - the FSM state type (IDLE, BUSY)
  - the counter width constant (6)
  - default MUL/DIV latency constants, also used by the EX-stage multiplier/divider
- Sub-module muldiv_stall_fsm contains the FSM and counter, and outputs Busy/Done. It is instantiated only under HAZARD_MULDIV_EN.
- hazard_unit holds the load-use compare and the priority mux.

## Test plan
- Load-use: EX_MemRead=1, EX_Rd=5, ID_Rs1=5, ID_UsesRs1=1 → one cycle of PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1. Next cycle (EX now holds the bubble) all defaults.
- Load of x0, or ID_UsesRs2=0 with ID_Rs2=EX_Rd=7 → no stall.
- EX_BranchTaken=1 together with a load-use match → IF_ID_Flush=1 and ID_EX_Flush=1, with PC_Write=1.
- DIV with DIV_CYCLES=33 → MulDiv_Busy=1 and EX_MEM_Bubble=1 for 32 cycles, MulDiv_Done=1 on cycle 33, then IDLE. MUL with MUL_CYCLES=3 → 2 stall cycles, Done on the 3rd.
- rst_n=0 at cycle 10 of a DIV → the next cycle is IDLE with all outputs at reset values, and no Done pulse.
- Build without HAZARD_MULDIV_EN, EX_MulDiv=1 → no stall, Busy and Done constant 0.

Source files
------------

// File: rtl/riscv_hazard_pkg.sv
// Shared hazard-control types and constants: M-op stall FSM states, counter width
// and the default MUL/DIV latencies also used by the EX-stage multiplier/divider.
package riscv_hazard_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } md_state_t;

   localparam int CNT_W          = 6;
   localparam int MUL_CYCLES_DEF = 3;
   localparam int DIV_CYCLES_DEF = 33;

   // Counter preload for a latency of lat: the entry cycle and the Done cycle are not counted.
   function automatic logic [CNT_W-1:0] lat_preload(input int lat);
      int tmp;
      tmp = lat - 2;
      return tmp[CNT_W-1:0];
   endfunction

endpackage

// File: rtl/muldiv_stall_fsm.sv
// Tracks EX occupancy by a multi-cycle M op; Busy stalls the front end, Done marks
// the final EX cycle. Instantiated by hazard_unit only under HAZARD_MULDIV_EN.
module muldiv_stall_fsm
   import riscv_hazard_pkg::*;
#(
   parameter int MUL_CYCLES = MUL_CYCLES_DEF,
   parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ex_muldiv,
   input  logic ex_isdiv,
   output logic busy,
   output logic done
);

   localparam logic             MUL_ONE  = (MUL_CYCLES == 1);
   localparam logic             DIV_ONE  = (DIV_CYCLES == 1);
   localparam logic [CNT_W-1:0] MUL_LOAD = lat_preload(MUL_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD = lat_preload(DIV_CYCLES);

   md_state_t        state_r;
   logic [CNT_W-1:0] cnt_r;
   logic             lat_one_s;

   // Done/Busy decode from the registered state and the incoming M op.
   always_comb begin
      lat_one_s = ex_isdiv ? DIV_ONE : MUL_ONE;
      done      = 1'b0;
      case (state_r)
         IDLE:    done = ex_muldiv & lat_one_s;
         BUSY:    done = (cnt_r == {CNT_W{1'b0}});
         default: done = 1'b0;
      endcase
      busy = ex_muldiv & ~done;
   end

   // State and down-counter; single-cycle ops never leave IDLE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
         cnt_r   <= {CNT_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (ex_muldiv && !lat_one_s) begin
                  state_r <= BUSY;
                  cnt_r   <= ex_isdiv ? DIV_LOAD : MUL_LOAD;
               end else begin
                  state_r <= IDLE;
               end
            end
            BUSY: begin
               if (cnt_r == {CNT_W{1'b0}}) begin
                  state_r <= IDLE;
               end else begin
                  cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            default: begin
               state_r <= IDLE;
               cnt_r   <= {CNT_W{1'b0}};
            end
         endcase
      end
   end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller between ID and EX: load-use stall, branch flush and
// M-op occupancy stall. Define HAZARD_MULDIV_EN to build in the MUL/DIV stall FSM.
module hazard_unit
   import riscv_hazard_pkg::*;
#(
   parameter int MUL_CYCLES = MUL_CYCLES_DEF,
   parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] ID_Rs1,
   input  logic [4:0] ID_Rs2,
   input  logic       ID_UsesRs1,
   input  logic       ID_UsesRs2,
   input  logic       EX_MemRead,
   input  logic [4:0] EX_Rd,
   input  logic       EX_BranchTaken,
   input  logic       EX_MulDiv,
   input  logic       EX_IsDiv,
   output logic       PC_Write,
   output logic       IF_ID_Write,
   output logic       IF_ID_Flush,
   output logic       ID_EX_Write,
   output logic       ID_EX_Flush,
   output logic       EX_MEM_Bubble,
   output logic       MulDiv_Busy,
   output logic       MulDiv_Done
);

   logic loaduse;
   logic md_busy;
   logic md_done;

`ifdef HAZARD_MULDIV_EN
   muldiv_stall_fsm #(
      .MUL_CYCLES (MUL_CYCLES),
      .DIV_CYCLES (DIV_CYCLES)
   ) u_muldiv_stall_fsm (
      .clk       (clk),
      .rst_n     (rst_n),
      .ex_muldiv (EX_MulDiv),
      .ex_isdiv  (EX_IsDiv),
      .busy      (md_busy),
      .done      (md_done)
   );
`else
   localparam int unused_lat = MUL_CYCLES + DIV_CYCLES;
   logic unused_inputs;
   assign unused_inputs = ^{clk, rst_n, EX_MulDiv, EX_IsDiv};
   assign md_busy = 1'b0;
   assign md_done = 1'b0;
`endif

   assign MulDiv_Busy = md_busy;
   assign MulDiv_Done = md_done;

   // Load-use: a load to a nonzero rd that the ID instruction actually reads.
   assign loaduse = EX_MemRead && (EX_Rd != 5'd0) &&
                    ((ID_UsesRs1 && (ID_Rs1 == EX_Rd)) ||
                     (ID_UsesRs2 && (ID_Rs2 == EX_Rd)));

   // Priority mux: M-op occupancy, then branch squash (which makes a load-use moot), then load-use.
   always_comb begin
      PC_Write      = 1'b1;
      IF_ID_Write   = 1'b1;
      IF_ID_Flush   = 1'b0;
      ID_EX_Write   = 1'b1;
      ID_EX_Flush   = 1'b0;
      EX_MEM_Bubble = 1'b0;
      if (md_busy) begin
         PC_Write      = 1'b0;
         IF_ID_Write   = 1'b0;
         ID_EX_Write   = 1'b0;
         EX_MEM_Bubble = 1'b1;
      end else if (EX_BranchTaken) begin
         IF_ID_Flush = 1'b1;
         ID_EX_Flush = 1'b1;
      end else if (loaduse) begin
         PC_Write    = 1'b0;
         IF_ID_Write = 1'b0;
         ID_EX_Flush = 1'b1;
      end else begin
         PC_Write = 1'b1;
      end
   end

endmodule
